// File: rtl/axi_lite_ram_if.sv
// axi_lite_ram_if: AXI4-Lite bus bundle for axi_lite_ram.
//   master modport: drives AR/AW/W channels and R/B readies (CPU side / bench).
//   slave  modport: drives AR/AW/W readies and the R/B channels (the RAM).
// Parameter DATA_W sets the data width; strobes are DATA_W/8 bits wide.
interface axi_lite_ram_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic [31:0]       araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [31:0]       awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI4-Lite slave RAM with programmable read/write latency,
// aligned word addressing and DECERR for addresses outside the backed window.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (0 = reset)
//   bus  - axi_lite_ram_if.slave: AR/R/AW/W/B channels
// Optional build macro AXI_LITE_RAM_STALL_EN adds an LFSR that randomly
// withholds readies and delays rvalid/bvalid entry (handshake timing only).
module axi_lite_ram #(
    parameter int          DATA_W     = 32,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0010_0000,
    parameter int          RD_LATENCY = 1,
    parameter int          WR_LATENCY = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    axi_lite_ram_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = int'(MEM_SIZE / NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Last aligned word address, computed in 33 bits so a window ending at
    // 4 GiB does not wrap.
    localparam logic [32:0] LAST_WORD = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'(NB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LATENCY - 1);

    // A zero seed would lock the LFSR at zero.
    if (LFSR_SEED == 16'h0) begin : g_zero_seed
        $error("axi_lite_ram: LFSR_SEED must be non-zero");
    end

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'(NB - 1);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] w;
        w = {1'b0, align(a)};
        return (w >= {1'b0, MEM_BASE}) && (w <= LAST_WORD);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((align(a) - MEM_BASE) >> LSB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Readies stay low until the first edge after reset release.
    logic rdy_en;
    logic stall_rdy;
    logic stall_rsp;

`ifdef AXI_LITE_RAM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall_rdy = lfsr[0];
    assign stall_rsp = lfsr[1];
`else
    assign stall_rdy = 1'b0;
    assign stall_rsp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_en <= 1'b0;
        else      rdy_en <= 1'b1;
    end

    // ---------------- read path ----------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    r_state_t          r_state, r_state_nx;
    logic [3:0]        r_cnt, r_cnt_nx;
    logic [IDX_W-1:0]  r_idx, r_idx_nx;
    logic              r_ok, r_ok_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic [1:0]        rresp_q, rresp_nx;
    logic              ar_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ok    <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nx;
            r_cnt   <= r_cnt_nx;
            r_idx   <= r_idx_nx;
            r_ok    <= r_ok_nx;
            rdata_q <= rdata_nx;
            rresp_q <= rresp_nx;
        end
    end

    always_comb begin
        r_state_nx = r_state;
        r_cnt_nx   = r_cnt;
        r_idx_nx   = r_idx;
        r_ok_nx    = r_ok;
        rdata_nx   = rdata_q;
        rresp_nx   = rresp_q;
        ar_rdy     = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = rdy_en & ~stall_rdy;
                if (bus.arvalid && ar_rdy) begin
                    r_idx_nx   = word_idx(bus.araddr);
                    r_ok_nx    = in_range(bus.araddr);
                    r_cnt_nx   = RD_CNT_INIT;
                    r_state_nx = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt != 4'd0) begin
                    r_cnt_nx = r_cnt - 4'd1;
                end else if (!stall_rsp) begin
                    // Sampled before any same-cycle commit lands: old data wins.
                    rdata_nx   = r_ok ? mem[r_idx] : '0;
                    rresp_nx   = r_ok ? RESP_OKAY : RESP_DECERR;
                    r_state_nx = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.rready) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    assign bus.arready = ar_rdy;
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // ---------------- write path ----------------
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    w_state_t          w_state, w_state_nx;
    logic [3:0]        w_cnt, w_cnt_nx;
    logic              aw_full, aw_full_nx;
    logic [IDX_W-1:0]  aw_idx, aw_idx_nx;
    logic              aw_ok, aw_ok_nx;
    logic              w_full, w_full_nx;
    logic [DATA_W-1:0] w_data, w_data_nx;
    logic [NB-1:0]     w_strb, w_strb_nx;
    logic [1:0]        bresp_q, bresp_nx;
    logic              aw_rdy, w_rdy, aw_hs, w_hs;
    logic              commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_full <= 1'b0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_state_nx;
            w_cnt   <= w_cnt_nx;
            aw_full <= aw_full_nx;
            aw_idx  <= aw_idx_nx;
            aw_ok   <= aw_ok_nx;
            w_full  <= w_full_nx;
            w_data  <= w_data_nx;
            w_strb  <= w_strb_nx;
            bresp_q <= bresp_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        w_cnt_nx   = w_cnt;
        aw_full_nx = aw_full;
        aw_idx_nx  = aw_idx;
        aw_ok_nx   = aw_ok;
        w_full_nx  = w_full;
        w_data_nx  = w_data;
        w_strb_nx  = w_strb;
        bresp_nx   = bresp_q;
        commit     = 1'b0;
        aw_rdy     = rdy_en & ~stall_rdy & ~aw_full & (w_state == W_IDLE);
        w_rdy      = rdy_en & ~stall_rdy & ~w_full  & (w_state == W_IDLE);
        aw_hs      = bus.awvalid & aw_rdy;
        w_hs       = bus.wvalid  & w_rdy;

        if (aw_hs) begin
            aw_full_nx = 1'b1;
            aw_idx_nx  = word_idx(bus.awaddr);
            aw_ok_nx   = in_range(bus.awaddr);
        end
        if (w_hs) begin
            w_full_nx = 1'b1;
            w_data_nx = bus.wdata;
            w_strb_nx = bus.wstrb;
        end

        case (w_state)
            W_IDLE: begin
                // Latency counts from the edge that completes the pair.
                if ((aw_full | aw_hs) && (w_full | w_hs)) begin
                    w_cnt_nx   = WR_CNT_INIT;
                    w_state_nx = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt != 4'd0) begin
                    w_cnt_nx = w_cnt - 4'd1;
                end else if (!stall_rsp) begin
                    commit     = aw_ok;
                    bresp_nx   = aw_ok ? RESP_OKAY : RESP_DECERR;
                    aw_full_nx = 1'b0;
                    w_full_nx  = 1'b0;
                    w_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb[i]) mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_ram.sv
// tb_axi_lite_ram: directed bench for axi_lite_ram (default build).
// dut0 uses default parameters; dut1 uses RD_LATENCY=4 and a 4 KiB window.
module tb_axi_lite_ram;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axi_lite_ram_if #(.DATA_W(32)) ifa ();
    axi_lite_ram_if #(.DATA_W(32)) ifb ();

    axi_lite_ram #(.DATA_W(32)) dut0 (.clk(clk), .rst(rst), .bus(ifa));
    axi_lite_ram #(.DATA_W(32), .MEM_SIZE(32'h0000_1000), .RD_LATENCY(4)) dut1 (
        .clk(clk), .rst(rst), .bus(ifb));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
        $fatal(1);
    end

    task automatic idle_inputs();
        ifa.araddr = '0; ifa.arvalid = 0; ifa.rready = 0;
        ifa.awaddr = '0; ifa.awvalid = 0; ifa.wdata = '0; ifa.wstrb = '0;
        ifa.wvalid = 0; ifa.bready = 0;
        ifb.araddr = '0; ifb.arvalid = 0; ifb.rready = 0;
        ifb.awaddr = '0; ifb.awvalid = 0; ifb.wdata = '0; ifb.wstrb = '0;
        ifb.wvalid = 0; ifb.bready = 0;
    endtask

    // AW and W together on dut0; lat = cycles from handshake edge to bvalid (-1 = timeout).
    task automatic wr0(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       output logic [1:0] resp, output int lat);
        int n;
        ifa.awaddr = addr; ifa.awvalid = 1;
        ifa.wdata = data; ifa.wstrb = strb; ifa.wvalid = 1;
        n = 0;
        while (!(ifa.awready && ifa.wready) && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ifa.awvalid = 0; ifa.wvalid = 0;
        lat = 0;
        while (!ifa.bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!ifa.bvalid) lat = -1;
        resp = ifa.bresp;
        ifa.bready = 1; @(posedge clk); #1; ifa.bready = 0;
    endtask

    task automatic rd0(input logic [31:0] addr, output logic [31:0] data,
                       output logic [1:0] resp, output int lat);
        int n;
        ifa.araddr = addr; ifa.arvalid = 1;
        n = 0;
        while (!ifa.arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ifa.arvalid = 0;
        lat = 0;
        while (!ifa.rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!ifa.rvalid) lat = -1;
        data = ifa.rdata; resp = ifa.rresp;
        ifa.rready = 1; @(posedge clk); #1; ifa.rready = 0;
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        ctl = {ifa.arready, ifa.awready, ifa.wready, ifa.rvalid, ifa.bvalid, ifa.rresp, ifa.bresp};
        checks++;
        if (ctl !== 9'h0) begin errors++; $display("FAIL reset_ctl: got=%h exp=%h", ctl, 9'h0); end
        checks++;
        if (ifa.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got=%h exp=%h", ifa.rdata, 32'h0); end
        rst = 1; #1;
        checks++;
        if ({ifa.arready, ifa.awready, ifa.wready} !== 3'b000) begin
            errors++; $display("FAIL ready_before_edge: got=%b exp=%b", {ifa.arready, ifa.awready, ifa.wready}, 3'b000);
        end
        @(posedge clk); #1;
        checks++;
        if ({ifa.arready, ifa.awready, ifa.wready, ifb.arready} !== 4'b1111) begin
            errors++; $display("FAIL ready_after_edge: got=%b exp=%b", {ifa.arready, ifa.awready, ifa.wready, ifb.arready}, 4'b1111);
        end
    endtask

    task automatic test_single_write_read();
        logic [1:0] resp; logic [31:0] data; int lat;
        wr0(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got=%b exp=%b", resp, 2'b00); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL wr_latency: got=%0d exp=%0d", lat, 1); end
        rd0(32'h8000_0012, data, resp, lat);
        checks++;
        if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got=%h exp=%h", data, 32'hDEAD_BEEF); end
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got=%b exp=%b", resp, 2'b00); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL rd_latency: got=%0d exp=%0d", lat, 1); end
    endtask

    task automatic test_byte_strobes();
        logic [1:0] resp; logic [31:0] data; int lat;
        wr0(32'h8000_0020, 32'hFFFF_FFFF, 4'hF, resp, lat);
        wr0(32'h8000_0020, 32'h1122_3344, 4'b0101, resp, lat);
        rd0(32'h8000_0020, data, resp, lat);
        checks++;
        if (data !== 32'hFF22_FF44) begin errors++; $display("FAIL strobe_merge: got=%h exp=%h", data, 32'hFF22_FF44); end
        wr0(32'h8000_0020, 32'h0000_0000, 4'h0, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL strobe_zero_bresp: got=%b exp=%b", resp, 2'b00); end
        rd0(32'h8000_0020, data, resp, lat);
        checks++;
        if (data !== 32'hFF22_FF44) begin errors++; $display("FAIL strobe_zero_data: got=%h exp=%h", data, 32'hFF22_FF44); end
    endtask

    task automatic test_write_order();
        logic [1:0] resp; logic [31:0] data; int lat;
        logic [31:0] addr, wd;
        logic [1:0] exp_rdy;
        bit extra_b;
        for (int ord = 0; ord < 2; ord++) begin
            addr = (ord == 0) ? 32'h8000_0030 : 32'h8000_0034;
            wd   = (ord == 0) ? 32'hF0F0_0002 : 32'h0F0F_0001;
            // {awready, wready} while the first-arrived half waits for its partner
            exp_rdy = (ord == 0) ? 2'b10 : 2'b01;
            if (ord == 0) begin ifa.wdata = wd; ifa.wstrb = 4'hF; ifa.wvalid = 1; end
            else          begin ifa.awaddr = addr; ifa.awvalid = 1; end
            @(posedge clk); #1;
            ifa.wvalid = 0; ifa.awvalid = 0;
            checks++;
            if ({ifa.awready, ifa.wready} !== exp_rdy) begin
                errors++; $display("FAIL order%0d_pending_rdy: got=%b exp=%b", ord, {ifa.awready, ifa.wready}, exp_rdy);
            end
            repeat (2) begin @(posedge clk); #1; end
            checks++;
            if ({ifa.awready, ifa.wready, ifa.bvalid} !== {exp_rdy, 1'b0}) begin
                errors++; $display("FAIL order%0d_still_pending: got=%b exp=%b", ord, {ifa.awready, ifa.wready, ifa.bvalid}, {exp_rdy, 1'b0});
            end
            if (ord == 0) begin ifa.awaddr = addr; ifa.awvalid = 1; end
            else          begin ifa.wdata = wd; ifa.wstrb = 4'hF; ifa.wvalid = 1; end
            @(posedge clk); #1;
            ifa.wvalid = 0; ifa.awvalid = 0;
            checks++;
            if ({ifa.awready, ifa.wready, ifa.bvalid} !== 3'b000) begin
                errors++; $display("FAIL order%0d_wwait: got=%b exp=%b", ord, {ifa.awready, ifa.wready, ifa.bvalid}, 3'b000);
            end
            @(posedge clk); #1;
            checks++;
            if ({ifa.awready, ifa.wready, ifa.bvalid, ifa.bresp} !== 5'b00100) begin
                errors++; $display("FAIL order%0d_wresp: got=%b exp=%b", ord, {ifa.awready, ifa.wready, ifa.bvalid, ifa.bresp}, 5'b00100);
            end
            ifa.bready = 1; @(posedge clk); #1; ifa.bready = 0;
            extra_b = 0;
            repeat (3) begin
                if (ifa.bvalid) extra_b = 1;
                @(posedge clk); #1;
            end
            checks++;
            if (extra_b !== 1'b0) begin errors++; $display("FAIL order%0d_single_b: got=%b exp=%b", ord, extra_b, 1'b0); end
            rd0(addr, data, resp, lat);
            checks++;
            if (data !== wd) begin errors++; $display("FAIL order%0d_data: got=%h exp=%h", ord, data, wd); end
        end
    endtask

    task automatic test_decode_error();
        logic [1:0] resp; logic [31:0] data; int lat;
        rd0(32'h7FFF_FFFC, data, resp, lat);
        checks++;
        if ({data, resp} !== {32'h0, 2'b11}) begin
            errors++; $display("FAIL decerr_rd_low: got=%h/%b exp=%h/%b", data, resp, 32'h0, 2'b11);
        end
        wr0(32'h800F_FFFC, 32'hCAFE_F00D, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL last_word_bresp: got=%b exp=%b", resp, 2'b00); end
        wr0(32'h8010_0000, 32'h1234_5678, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b11) begin errors++; $display("FAIL decerr_wr_high: got=%b exp=%b", resp, 2'b11); end
        rd0(32'h800F_FFFC, data, resp, lat);
        checks++;
        if (data !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word_kept: got=%h exp=%h", data, 32'hCAFE_F00D); end
        rd0(32'h8010_0000, data, resp, lat);
        checks++;
        if ({data, resp} !== {32'h0, 2'b11}) begin
            errors++; $display("FAIL decerr_rd_high: got=%h/%b exp=%h/%b", data, resp, 32'h0, 2'b11);
        end
    endtask

    task automatic test_rd_latency();
        int n, lat;
        bit hold_bad;
        ifb.awaddr = 32'h8000_0040; ifb.awvalid = 1;
        ifb.wdata = 32'hA5A5_5A5A; ifb.wstrb = 4'hF; ifb.wvalid = 1;
        @(posedge clk); #1;
        ifb.awvalid = 0; ifb.wvalid = 0;
        n = 0;
        while (!ifb.bvalid && n < 50) begin @(posedge clk); #1; n++; end
        ifb.bready = 1; @(posedge clk); #1; ifb.bready = 0;

        checks++;
        if (ifb.arready !== 1'b1) begin errors++; $display("FAIL lat4_arready_idle: got=%b exp=%b", ifb.arready, 1'b1); end
        ifb.araddr = 32'h8000_0040; ifb.arvalid = 1;
        @(posedge clk); #1;
        ifb.arvalid = 0;
        checks++;
        if (ifb.arready !== 1'b0) begin errors++; $display("FAIL lat4_arready_wait: got=%b exp=%b", ifb.arready, 1'b0); end
        lat = 0;
        while (!ifb.rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL lat4_latency: got=%0d exp=%0d", lat, 4); end
        checks++;
        if ({ifb.rdata, ifb.rresp} !== {32'hA5A5_5A5A, 2'b00}) begin
            errors++; $display("FAIL lat4_data: got=%h/%b exp=%h/%b", ifb.rdata, ifb.rresp, 32'hA5A5_5A5A, 2'b00);
        end
        hold_bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ifb.rvalid !== 1'b1 || ifb.rdata !== 32'hA5A5_5A5A || ifb.arready !== 1'b0) hold_bad = 1;
        end
        checks++;
        if (hold_bad !== 1'b0) begin errors++; $display("FAIL lat4_hold_stable: got=%b exp=%b", hold_bad, 1'b0); end
        ifb.rready = 1; @(posedge clk); #1; ifb.rready = 0;
        checks++;
        if ({ifb.rvalid, ifb.arready} !== 2'b01) begin
            errors++; $display("FAIL lat4_after_r: got=%b exp=%b", {ifb.rvalid, ifb.arready}, 2'b01);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] resp; logic [31:0] data; int lat;
        logic [8:0] ctl;
        bit b_seen;
        wr0(32'h8000_0080, 32'h0BAD_F00D, 4'hF, resp, lat);
        rd0(32'h8000_0080, data, resp, lat);
        ifa.awaddr = 32'h8000_0080; ifa.awvalid = 1;
        ifa.wdata = 32'h7777_7777; ifa.wstrb = 4'hF; ifa.wvalid = 1;
        @(posedge clk); #1;
        // handshake has happened; the DUT is now in its wait state
        rst = 0; #1;
        ifa.awvalid = 0; ifa.wvalid = 0;
        ctl = {ifa.arready, ifa.awready, ifa.wready, ifa.rvalid, ifa.bvalid, ifa.rresp, ifa.bresp};
        checks++;
        if ({ctl, ifa.rdata} !== 41'h0) begin
            errors++; $display("FAIL async_reset_outputs: got=%h/%h exp=%h/%h", ctl, ifa.rdata, 9'h0, 32'h0);
        end
        b_seen = 0;
        repeat (2) begin @(posedge clk); #1; if (ifa.bvalid) b_seen = 1; end
        rst = 1;
        repeat (3) begin @(posedge clk); #1; if (ifa.bvalid) b_seen = 1; end
        checks++;
        if (b_seen !== 1'b0) begin errors++; $display("FAIL reset_no_bvalid: got=%b exp=%b", b_seen, 1'b0); end
        rd0(32'h8000_0080, data, resp, lat);
        checks++;
        if (data !== 32'h0BAD_F00D) begin errors++; $display("FAIL reset_no_commit: got=%h exp=%h", data, 32'h0BAD_F00D); end
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_byte_strobes();
        test_write_order();
        test_decode_error();
        test_rd_latency();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_ram.md
Name: axi_lite_ram

Overview:
- Parametrised AXI4-Lite slave RAM for the simulation SoC; successor of the fixed 32-bit single-latency RAM.
- Generalised data width, base/size and programmable read/write latency.
- Adds `rresp`, read-side decode errors, aligned addressing and strict valid/ready compliance.
- Sits on the core's memory bus behind the fetch/LSU arbiter.

Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64; byte lanes NB = DATA_W/8.
- MEM_BASE, 32'h8000_0000, first byte address backed by storage.
- MEM_SIZE, 32'h0010_0000, storage size in bytes; multiple of NB.
- RD_LATENCY, 1, cycles from AR handshake to `rvalid`; range 1..15.
- WR_LATENCY, 1, cycles from both AW and W buffered to `bvalid`; range 1..15.
- LFSR_SEED, 16'hACE1, seed for the optional stall generator; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  NB  byte write strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (rst=0, asynchronous): `rvalid`=`bvalid`=0, `rdata`=0, `rresp`=`bresp`=0, all readies 0, both FSMs idle, AW/W buffers empty, latency counters 0. Memory contents are not reset. Readies rise on the first clock edge after `rst` goes to 1.
- Reset mid-transaction: the in-flight transaction is dropped; no memory write; no response is issued.
- Address alignment: address bits [log2(NB)-1:0] are ignored; the beat covers an aligned NB-byte word.
- Range check on the aligned address A: in range iff MEM_BASE <= A <= MEM_BASE+MEM_SIZE-NB, evaluated without 32-bit overflow.
- Response codes: OKAY=2'b00, DECERR=2'b11.
- Read FSM, R_IDLE:
  - `arready`=1.
  - On `arvalid`&`arready`: capture the address, load counter=RD_LATENCY-1, go to R_WAIT.
- Read FSM, R_WAIT:
  - `arready`=0; counter decrements each cycle.
  - In the cycle the counter is 0, sample memory (rdata=word, rresp=OKAY) or, if out of range, rdata=0 and rresp=DECERR. Go to R_RESP.
  - `rvalid` therefore rises exactly RD_LATENCY cycles after the AR handshake edge.
- Read FSM, R_RESP:
  - `rvalid`=1; `rdata`/`rresp` stay stable while `rready`=0.
  - On `rready`: `rvalid`=0, return to R_IDLE.
  - No AR acceptance in the same cycle, so minimum read period is RD_LATENCY+2 cycles.
- Write buffers:
  - `awready` = !aw_buf_full & write FSM in W_IDLE.
  - `wready` = !w_buf_full & write FSM in W_IDLE.
  - AW and W may arrive in either order or the same cycle; each is held until its partner arrives.
- Write FSM, W_IDLE: when both buffers are full, load counter=WR_LATENCY-1 and go to W_WAIT.
- Write FSM, W_WAIT:
  - When the counter is 0: if in range, write each byte lane i where wstrb[i]=1 (lanes with strobe 0 are unchanged) and set bresp=OKAY; else no write and bresp=DECERR.
  - Clear both buffers and go to W_RESP.
- Write FSM, W_RESP: `bvalid`=1 and held with `bresp` stable until `bready`, then return to W_IDLE.
- Read and write paths are fully independent.
- Read sample and write commit to the same word in the same cycle: the read returns old data.
- `wstrb`=0 in range: no bytes change; bresp=OKAY.

Optional Feature:
- Macro: AXI_LITE_RAM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, advances every cycle.
  - `arready`, `awready` and `wready` are additionally ANDed with !lfsr[0].
  - `rvalid` entry from R_WAIT and `bvalid` entry from W_WAIT are delayed by one cycle whenever lfsr[1]=1 at the would-be entry cycle.
  - Stalls stretch handshakes only; data and responses are unchanged.
- Undefined: no LFSR; timing is exactly as in Behaviour.

Test Plan:
- Reset then single write: aw=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, DATA_W=32, WR_LATENCY=1 -> `bvalid` one cycle after both buffered, bresp=00. Read of 0x8000_0012 -> rdata=0xDEADBEEF, rresp=00, `rvalid` exactly 1 cycle after AR handshake.
- Byte strobes: write 0x11223344 with wstrb=4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
- W presented 3 cycles before AW, then the same order reversed -> a single commit each time. `awready`/`wready` low while the partner is pending, then low during W_WAIT/W_RESP.
- Decode error: read 0x7FFF_FFFC -> rdata=0, rresp=11. Write to MEM_BASE+MEM_SIZE -> bresp=11 and the last in-range word is unchanged.
- RD_LATENCY=4 with `rready` held low 5 cycles -> `rvalid` at +4, `rdata` stable throughout, `arready` low until one cycle after the R handshake.
- Assert `rst`=0 asynchronously during W_WAIT -> `bvalid` never rises; the target word keeps its old value; all outputs read as reset values immediately.
